// File: rtl/dm_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dm_arbiter_pkg
// Shared encodings for the data-memory arbiter: DM write/read request codes
// (as driven by the CPU control unit), arbiter state encoding and a small
// helper that turns a burst beat index into a byte offset.
// -----------------------------------------------------------------------------
package dm_arbiter_pkg;

    // DM write code. Anything other than DMWR_NONE is a write request.
    typedef enum logic [1:0] {
        DMWR_NONE = 2'b00,
        DMWR_WORD = 2'b01,
        DMWR_HALF = 2'b10,
        DMWR_BYTE = 2'b11
    } dmwr_e;

    // DM read code. Anything other than DMRE_NONE is a read request.
    typedef enum logic [2:0] {
        DMRE_NONE  = 3'b000,
        DMRE_WORD  = 3'b001,
        DMRE_HALF  = 3'b010,
        DMRE_HALFU = 3'b011,
        DMRE_BYTE  = 3'b100,
        DMRE_BYTEU = 3'b101
    } dmre_e;

    // Memory ownership: CPU in IDLE, external port in BURST.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Byte offset of a word beat inside a burst (beat * 4).
    function automatic logic [4:0] beat_offset(input logic [2:0] beat);
        return {beat, 2'b00};
    endfunction

endpackage

// File: rtl/dm_arbiter_seq.sv
// -----------------------------------------------------------------------------
// ext_burst_seq
// Beat sequencer for an external-port burst: latches the burst descriptor at
// grant, counts beats while the burst owns the DM, generates the word address
// (wrapping modulo the DM size) and flags the last beat.
// Ports:
//   i_clk, i_rst_n  clock / async active-low reset
//   i_start         grant pulse; latches i_we, i_addr, i_len and clears the beat count
//   i_active        burst currently owns the DM (one beat per cycle)
//   i_we, i_addr, i_len  burst descriptor sampled on i_start
//   o_we            latched direction (1 = write burst)
//   o_addr          DM byte address of the current beat
//   o_done          current beat is the last one
// -----------------------------------------------------------------------------
module ext_burst_seq
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_active,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_len,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_done
);

    // Low two address bits are dropped so every beat is a whole word.
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_len;
    logic              r_we;
    logic [2:0]        r_beat;
    logic [ADDR_W-1:0] w_offset;

    // Descriptor latch and beat counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base <= '0;
            r_len  <= 3'd0;
            r_we   <= 1'b0;
            r_beat <= 3'd0;
        end else if (i_start) begin
            r_base <= i_addr & WORD_MASK;
            r_len  <= i_len;
            r_we   <= i_we;
            r_beat <= 3'd0;
        end else if (i_active) begin
            r_beat <= r_beat + 3'd1;
        end else begin
            r_beat <= r_beat;
        end
    end

    // Truncating add gives the required wrap at the top of the DM.
    assign w_offset = ADDR_W'(beat_offset(r_beat));
    assign o_addr   = r_base + w_offset;
    assign o_we     = r_we;
    assign o_done   = i_active & (r_beat == r_len);

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Shares the single data memory between the CPU load/store path and an
// external burst port. The CPU owns the DM by default with zero latency; the
// external port is granted when the CPU is idle, or forcibly after the CPU has
// won STARVE_LIMIT consecutive contested cycles. A granted burst runs
// ext_len+1 word beats, one per cycle, and stalls the CPU if it requests.
// Ports:
//   i_clk, i_rst_n             clock / async active-low reset
//   i_cpu_we/re/addr/wdata     CPU DM request (codes from dm_arbiter_pkg)
//   o_cpu_rdata, o_cpu_stall   DM read data to CPU, CPU hold request
//   i_ext_req/we/addr/len      external burst request and descriptor
//   i_ext_wdata                write data for the current beat
//   o_ext_gnt, o_ext_done      beat strobe, last-beat strobe
//   o_ext_rvalid, o_ext_rdata  registered read data, one cycle after each read beat
//   o_dm_we/re/addr/wdata      DM request, i_dm_rdata combinational DM read data
// -----------------------------------------------------------------------------
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_cpu_we,
    input  logic [2:0]        i_cpu_re,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_stall,
    input  logic              i_ext_req,
    input  logic              i_ext_we,
    input  logic [ADDR_W-1:0] i_ext_addr,
    input  logic [2:0]        i_ext_len,
    input  logic [DATA_W-1:0] i_ext_wdata,
    output logic              o_ext_gnt,
    output logic              o_ext_rvalid,
    output logic [DATA_W-1:0] o_ext_rdata,
    output logic              o_ext_done,
    output logic [1:0]        o_dm_we,
    output logic [2:0]        o_dm_re,
    output logic [ADDR_W-1:0] o_dm_addr,
    output logic [DATA_W-1:0] o_dm_wdata,
    input  logic [DATA_W-1:0] i_dm_rdata
);

    localparam int               CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_starve;
    logic              r_ext_rvalid;
    logic [DATA_W-1:0] r_ext_rdata;

    logic              w_cpu_req;
    logic              w_go_ext;
    logic              w_burst;
    logic              w_seq_we;
    logic [ADDR_W-1:0] w_seq_addr;
    logic              w_seq_done;

    assign w_cpu_req = (i_cpu_we != DMWR_NONE) | (i_cpu_re != DMRE_NONE);
    assign w_burst   = (r_state == ST_BURST);
    // Grant when the CPU leaves the DM free, or when it has starved the port.
    assign w_go_ext  = (r_state == ST_IDLE) & i_ext_req &
                       (~w_cpu_req | (r_starve == STARVE_MAX));

    ext_burst_seq #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (w_go_ext),
        .i_active (w_burst),
        .i_we     (i_ext_we),
        .i_addr   (i_ext_addr),
        .i_len    (i_ext_len),
        .o_we     (w_seq_we),
        .o_addr   (w_seq_addr),
        .o_done   (w_seq_done)
    );

    // Ownership state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and DM/handshake mux; CPU path is the default owner.
    always_comb begin
        w_state_nxt = r_state;
        o_dm_we     = i_cpu_we;
        o_dm_re     = i_cpu_re;
        o_dm_addr   = i_cpu_addr;
        o_dm_wdata  = i_cpu_wdata;
        o_cpu_stall = 1'b0;
        o_ext_gnt   = 1'b0;
        o_ext_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go_ext) begin
                    w_state_nxt = ST_BURST;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BURST: begin
                o_ext_gnt   = 1'b1;
                o_cpu_stall = w_cpu_req;
                o_dm_addr   = w_seq_addr;
                o_dm_wdata  = i_ext_wdata;
                o_ext_done  = w_seq_done;
                if (w_seq_we) begin
                    o_dm_we = DMWR_WORD;
                    o_dm_re = DMRE_NONE;
                end else begin
                    o_dm_we = DMWR_NONE;
                    o_dm_re = DMRE_WORD;
                end
                // At least one IDLE cycle separates bursts, so the CPU is re-arbitrated.
                if (w_seq_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BURST;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Starvation counter: consecutive IDLE cycles where the CPU beat a pending ext request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_go_ext || !i_ext_req) begin
                r_starve <= '0;
            end else if (r_starve != STARVE_MAX) begin
                r_starve <= r_starve + CNT_W'(1);
            end else begin
                r_starve <= r_starve;
            end
        end else begin
            r_starve <= r_starve;
        end
    end

    // Read-beat capture: data and valid appear the cycle after each read beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ext_rvalid <= 1'b0;
            r_ext_rdata  <= '0;
        end else if (w_burst && !w_seq_we) begin
            r_ext_rvalid <= 1'b1;
            r_ext_rdata  <= i_dm_rdata;
        end else begin
            r_ext_rvalid <= 1'b0;
            r_ext_rdata  <= r_ext_rdata;
        end
    end

    assign o_ext_rvalid = r_ext_rvalid;
    assign o_ext_rdata  = r_ext_rdata;
    // The CPU only uses read data when it owns the DM; in a burst it is stalled.
    assign o_cpu_rdata  = i_dm_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
// Directed bench for dm_arbiter with a word-addressed DM model attached. A
// cycle-level ownership model (who owns the DM, beats left, contested-cycle
// count, pending read data) predicts every output each cycle; literal checks
// pin the scenario results.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  cpu_we;
    logic [2:0]  cpu_re;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] o_cpu_rdata;
    logic        o_cpu_stall;
    logic        ext_req;
    logic        ext_we;
    logic [9:0]  ext_addr;
    logic [2:0]  ext_len;
    logic [31:0] ext_wdata;
    logic        o_ext_gnt;
    logic        o_ext_rvalid;
    logic [31:0] o_ext_rdata;
    logic        o_ext_done;
    logic [1:0]  o_dm_we;
    logic [2:0]  o_dm_re;
    logic [9:0]  o_dm_addr;
    logic [31:0] o_dm_wdata;
    logic [31:0] dm_rdata;

    logic [31:0] mem [256];
    logic        init_r = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Ownership model state.
    int          m_left;
    int          m_beat;
    int          m_wins;
    logic        m_we;
    logic [9:0]  m_base;
    logic        m_rv;
    logic [31:0] m_rd;

    int idle_cnt;
    int stall_cnt;

    dm_arbiter dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cpu_we     (cpu_we),
        .i_cpu_re     (cpu_re),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_rdata  (o_cpu_rdata),
        .o_cpu_stall  (o_cpu_stall),
        .i_ext_req    (ext_req),
        .i_ext_we     (ext_we),
        .i_ext_addr   (ext_addr),
        .i_ext_len    (ext_len),
        .i_ext_wdata  (ext_wdata),
        .o_ext_gnt    (o_ext_gnt),
        .o_ext_rvalid (o_ext_rvalid),
        .o_ext_rdata  (o_ext_rdata),
        .o_ext_done   (o_ext_done),
        .o_dm_we      (o_dm_we),
        .o_dm_re      (o_dm_re),
        .o_dm_addr    (o_dm_addr),
        .o_dm_wdata   (o_dm_wdata),
        .i_dm_rdata   (dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DM: combinational read, word write on the rising edge; filled with a pattern first.
    always @(posedge clk) begin
        if (!init_r) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
            init_r <= 1'b1;
        end else if (o_dm_we == 2'b01) begin
            mem[o_dm_addr[9:2]] <= o_dm_wdata;
        end
    end
    assign dm_rdata = mem[o_dm_addr[9:2]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    // Predict this cycle's outputs, compare, then advance the model to the next cycle.
    task automatic model_cycle();
        logic       cpu_req;
        logic [9:0] a;
        if (!rst_n) begin
            m_left = 0; m_beat = 0; m_wins = 0; m_rv = 1'b0; m_rd = 32'h0;
        end
        cpu_req = (cpu_we != 2'b00) || (cpu_re != 3'b000);
        a = m_base + 10'(4 * m_beat);
        if (m_left == 0) begin
            chk("m_dm_we",   32'(o_dm_we),    32'(cpu_we));
            chk("m_dm_re",   32'(o_dm_re),    32'(cpu_re));
            chk("m_dm_addr", 32'(o_dm_addr),  32'(cpu_addr));
            chk("m_dm_wdata", o_dm_wdata,     cpu_wdata);
            chk("m_cpu_rdata", o_cpu_rdata,   mem[cpu_addr[9:2]]);
            chk("m_stall",   32'(o_cpu_stall), 32'h0);
            chk("m_gnt",     32'(o_ext_gnt),   32'h0);
            chk("m_done",    32'(o_ext_done),  32'h0);
        end else begin
            chk("m_dm_we",   32'(o_dm_we),    m_we ? 32'h1 : 32'h0);
            chk("m_dm_re",   32'(o_dm_re),    m_we ? 32'h0 : 32'h1);
            chk("m_dm_addr", 32'(o_dm_addr),  32'(a));
            chk("m_dm_wdata", o_dm_wdata,     ext_wdata);
            chk("m_stall",   32'(o_cpu_stall), 32'(cpu_req));
            chk("m_gnt",     32'(o_ext_gnt),   32'h1);
            chk("m_done",    32'(o_ext_done),  (m_left == 1) ? 32'h1 : 32'h0);
        end
        chk("m_rvalid", 32'(o_ext_rvalid), 32'(m_rv));
        chk("m_rdata",  o_ext_rdata,       m_rd);
        if (rst_n) begin
            m_rv = 1'b0;
            if (m_left > 0) begin
                if (!m_we) begin
                    m_rd = mem[a[9:2]];
                    m_rv = 1'b1;
                end
                m_beat++;
                m_left--;
            end else if (ext_req && (!cpu_req || m_wins == 4)) begin
                m_left = int'(ext_len) + 1;
                m_base = ext_addr & 10'h3FC;
                m_we   = ext_we;
                m_beat = 0;
                m_wins = 0;
            end else if (ext_req) begin
                m_wins = (m_wins < 4) ? m_wins + 1 : 4;
            end else begin
                m_wins = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_cycle();
    endtask

    task automatic adv();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; cpu_we = 2'b00; cpu_re = 3'b000; cpu_addr = 10'h000;
        cpu_wdata = 32'h0; ext_req = 1'b0; ext_we = 1'b0; ext_addr = 10'h000;
        ext_len = 3'd0; ext_wdata = 32'h0;
        m_left = 0; m_beat = 0; m_wins = 0; m_we = 1'b0; m_base = 10'h000;
        m_rv = 1'b0; m_rd = 32'h0;
        idle_cnt = 0; stall_cnt = 0;

        // Reset
        repeat (3) begin
            tick();
            adv();
        end
        rst_n = 1'b1;
        tick(); adv();

        // CPU store then load, no stall
        cpu_we = 2'b01; cpu_addr = 10'h010; cpu_wdata = 32'hDEAD_BEEF;
        tick(); adv();
        cpu_we = 2'b00; cpu_re = 3'b001;
        tick();
        chk("lw_data",  o_cpu_rdata, 32'hDEAD_BEEF);
        chk("lw_stall", 32'(o_cpu_stall), 32'h0);
        adv();
        cpu_re = 3'b000;
        tick(); adv();

        // Write burst len=3 @0x100; request dropped and descriptor changed after grant
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 10'h100; ext_len = 3'd3;
        tick();
        chk("wb_pre_gnt", 32'(o_ext_gnt), 32'h0);
        adv();
        ext_req = 1'b0; ext_addr = 10'h000; ext_len = 3'd0;
        for (int b = 0; b < 4; b++) begin
            ext_wdata = 32'h1111_0000 + 32'(b);
            tick();
            chk("wb_gnt",  32'(o_ext_gnt),  32'h1);
            chk("wb_done", 32'(o_ext_done), (b == 3) ? 32'h1 : 32'h0);
            chk("wb_addr", 32'(o_dm_addr),  32'h100 + 32'(4 * b));
            adv();
        end
        tick();
        chk("wb_idle_after", 32'(o_ext_gnt), 32'h0);
        adv();
        for (int b = 0; b < 4; b++) chk("wb_mem", mem[64 + b], 32'h1111_0000 + 32'(b));

        // Read burst len=1 from unaligned 0x3FE: wraps 0x3FC -> 0x000
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 10'h3FE; ext_len = 3'd1;
        tick(); adv();
        ext_req = 1'b0;
        tick();
        chk("rd_addr0",  32'(o_dm_addr),    32'h3FC);
        chk("rd_rv0",    32'(o_ext_rvalid), 32'h0);
        adv();
        tick();
        chk("rd_addr1",  32'(o_dm_addr),    32'h000);
        chk("rd_rv1",    32'(o_ext_rvalid), 32'h1);
        chk("rd_data0",  o_ext_rdata,       32'hA5A5_00FF);
        adv();
        tick();
        chk("rd_rv2",    32'(o_ext_rvalid), 32'h1);
        chk("rd_data1",  o_ext_rdata,       32'hA5A5_0000);
        chk("rd_gnt_end", 32'(o_ext_gnt),   32'h0);
        adv();
        tick();
        chk("rd_rv3",    32'(o_ext_rvalid), 32'h0);
        adv();

        // Starvation: CPU reads every cycle while ext write len=2 is pending
        cpu_re = 3'b001; cpu_addr = 10'h010;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 10'h200; ext_len = 3'd2;
        ext_wdata = 32'hCAFE_0000;
        idle_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (o_ext_gnt) break;
            idle_cnt++;
            adv();
        end
        chk("starve_cpu_cycles", 32'(idle_cnt), 32'd5);
        stall_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (!o_ext_gnt) break;
            if (o_cpu_stall) stall_cnt++;
            adv();
            ext_req = 1'b0;
            tick();
        end
        chk("starve_stall_cycles", 32'(stall_cnt), 32'd3);
        adv();
        cpu_re = 3'b000;
        for (int b = 0; b < 3; b++) chk("st_mem", mem[128 + b], 32'hCAFE_0000);
        chk("st_mem_past_end", mem[131], 32'hA5A5_0083);
        tick(); adv();

        // Reset during the second beat of a len=7 write burst
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 10'h280; ext_len = 3'd7;
        tick(); adv();
        ext_req = 1'b0; ext_wdata = 32'h7777_0000;
        tick();
        chk("rs_gnt_beat0", 32'(o_ext_gnt), 32'h1);
        adv();
        ext_wdata = 32'h7777_0001;
        rst_n = 1'b0;
        tick();
        chk("rs_gnt",    32'(o_ext_gnt),    32'h0);
        chk("rs_stall",  32'(o_cpu_stall),  32'h0);
        chk("rs_done",   32'(o_ext_done),   32'h0);
        chk("rs_rvalid", 32'(o_ext_rvalid), 32'h0);
        chk("rs_rdata",  o_ext_rdata,       32'h0);
        adv();
        tick(); adv();
        rst_n = 1'b1;
        tick(); adv();
        tick(); adv();
        chk("rs_mem_beat0", mem[160], 32'h7777_0000);
        for (int b = 1; b < 8; b++) chk("rs_mem_untouched", mem[160 + b], 32'hA5A5_0000 | 32'(160 + b));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
